// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bit positions
// shared by the sequential ALU and its bench-facing top.
package alu_seq_pkg;

  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB = 6'b100010;
  localparam logic [OPW-1:0] OP_AND = 6'b100100;
  localparam logic [OPW-1:0] OP_OR  = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR = 6'b100110;
  localparam logic [OPW-1:0] OP_NOR = 6'b100111;
  localparam logic [OPW-1:0] OP_SRL = 6'b000010;
  localparam logic [OPW-1:0] OP_SRA = 6'b000011;
  localparam logic [OPW-1:0] OP_MUL = 6'b011000;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;
  localparam int NFLG  = 4;

endpackage

// File: rtl/alu_seq_unit_edge_sync.sv
// edge_sync: two-flop synchroniser followed by a
// rising-edge detector producing a one-cycle pulse.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic s0;
  logic s1;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= level;
      s1   <= s0;
      prev <= s1;
    end
  end

  assign pulse = s1 & ~prev;

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: button-loaded ALU with registered flags
// and a multi-cycle shift-add unsigned multiplier.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_enable_1,
  input  logic               i_enable_2,
  input  logic               i_enable_3,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_carry,
  output logic               o_zero,
  output logic               o_overflow,
  output logic               o_negative,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_error
);

  localparam int SHW = $clog2(NB_DATA);
  localparam int CW  = $clog2(NB_DATA + 1);
  localparam int OW  = (NB_OP > OPW) ? NB_OP : OPW;
  localparam int N   = NB_DATA;

  state_t state;
  state_t state_n;

  logic ld_a;
  logic ld_b;
  logic ld_op;

  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [NB_OP-1:0] op_q;
  logic [OW-1:0]    opx;

  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] mcand_q;
  logic [N-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] acc_step;
  logic           mul_last;

  logic [N-1:0]    data_q;
  logic [NFLG-1:0] flg_q;
  logic            valid_q;
  logic            err_q;

  logic [N:0]     sum_add;
  logic [N:0]     sum_sub;
  logic           ovf_add;
  logic           ovf_sub;
  logic [SHW-1:0] sh;
  logic [N-1:0]   sra_r;

  logic [N-1:0] res;
  logic         cout;
  logic         ovf;
  logic         legal;
  logic         is_mul;

  edge_sync u_sync_a (
    .clk   (i_clk),
    .rst_n (i_reset),
    .level (i_enable_1),
    .pulse (ld_a)
  );

  edge_sync u_sync_b (
    .clk   (i_clk),
    .rst_n (i_reset),
    .level (i_enable_2),
    .pulse (ld_b)
  );

  edge_sync u_sync_op (
    .clk   (i_clk),
    .rst_n (i_reset),
    .level (i_enable_3),
    .pulse (ld_op)
  );

  function automatic logic [NFLG-1:0] mk_flg(
    input logic [N-1:0] r,
    input logic         c,
    input logic         v
  );
    mk_flg        = '0;
    mk_flg[FLG_C] = c;
    mk_flg[FLG_Z] = (r == '0);
    mk_flg[FLG_V] = v;
    mk_flg[FLG_N] = r[N-1];
  endfunction

  assign opx = OW'(op_q);

  // SUB is A + ~B + 1, so carry-out high means no borrow
  assign sum_add = {1'b0, a_q} + {1'b0, b_q};
  assign sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + (N+1)'(1);

  assign ovf_add = (a_q[N-1] == b_q[N-1])
                 & (sum_add[N-1] != a_q[N-1]);
  assign ovf_sub = (a_q[N-1] != b_q[N-1])
                 & (sum_sub[N-1] != a_q[N-1]);

  assign sh    = b_q[SHW-1:0];
  assign sra_r = $unsigned($signed(a_q) >>> sh);

  always_comb begin
    res    = '0;
    cout   = 1'b0;
    ovf    = 1'b0;
    legal  = 1'b1;
    is_mul = 1'b0;
    unique case (1'b1)
      opx == OW'(OP_ADD): begin
        res  = sum_add[N-1:0];
        cout = sum_add[N];
        ovf  = ovf_add;
      end
      opx == OW'(OP_SUB): begin
        res  = sum_sub[N-1:0];
        cout = sum_sub[N];
        ovf  = ovf_sub;
      end
      opx == OW'(OP_AND): res = a_q & b_q;
      opx == OW'(OP_OR):  res = a_q | b_q;
      opx == OW'(OP_XOR): res = a_q ^ b_q;
      opx == OW'(OP_NOR): res = ~(a_q | b_q);
      opx == OW'(OP_SRL): res = a_q >> sh;
      opx == OW'(OP_SRA): res = sra_r;
      opx == OW'(OP_MUL): is_mul = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign mul_last = (cnt_q == CW'(1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (ld_op) state_n = EXEC;
      EXEC: state_n = is_mul ? MUL : IDLE;
      MUL:  if (mul_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      flg_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ld_a)  a_q  <= i_data;
          if (ld_b)  b_q  <= i_data;
          if (ld_op) op_q <= i_data[NB_OP-1:0];
        end
        EXEC: begin
          if (!legal) begin
            err_q   <= 1'b1;
            valid_q <= 1'b1;
          end else if (is_mul) begin
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, a_q};
            mplier_q <= b_q;
            cnt_q    <= CW'(N);
          end else begin
            data_q  <= res;
            flg_q   <= mk_flg(res, cout, ovf);
            err_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (mul_last) begin
            data_q  <= acc_step[N-1:0];
            flg_q   <= mk_flg(acc_step[N-1:0],
                              |acc_step[2*N-1:N],
                              |acc_step[2*N-1:N]);
            err_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data     = data_q;
  assign o_carry    = flg_q[FLG_C];
  assign o_zero     = flg_q[FLG_Z];
  assign o_overflow = flg_q[FLG_V];
  assign o_negative = flg_q[FLG_N];
  assign o_busy     = (state != IDLE);
  assign o_valid    = valid_q;
  assign o_error    = err_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed plus randomized operations
// checked against an arithmetic reference model.
module tb_alu_seq_unit;

  localparam int N = 8;

  localparam logic [5:0] T_ADD = 6'b100000;
  localparam logic [5:0] T_SUB = 6'b100010;
  localparam logic [5:0] T_AND = 6'b100100;
  localparam logic [5:0] T_OR  = 6'b100101;
  localparam logic [5:0] T_XOR = 6'b100110;
  localparam logic [5:0] T_NOR = 6'b100111;
  localparam logic [5:0] T_SRL = 6'b000010;
  localparam logic [5:0] T_SRA = 6'b000011;
  localparam logic [5:0] T_MUL = 6'b011000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_data;
  logic         en1, en2, en3;
  logic [N-1:0] o_data;
  logic         o_carry, o_zero, o_overflow;
  logic         o_negative, o_busy, o_valid, o_error;

  always #5 clk = ~clk;

  alu_seq_unit #(.NB_DATA(N), .NB_OP(6)) dut (
    .i_clk      (clk),
    .i_reset    (rst_n),
    .i_data     (i_data),
    .i_enable_1 (en1),
    .i_enable_2 (en2),
    .i_enable_3 (en3),
    .o_data     (o_data),
    .o_carry    (o_carry),
    .o_zero     (o_zero),
    .o_overflow (o_overflow),
    .o_negative (o_negative),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_error    (o_error)
  );

  int checks = 0;
  int errors = 0;

  int ma, mb;
  int e_data;
  bit e_c, e_z, e_v, e_n, e_err;

  logic [5:0] ops [9] = '{T_ADD, T_SUB, T_AND, T_OR,
                          T_XOR, T_NOR, T_SRL, T_SRA, T_MUL};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, " data"}, 32'(o_data), 32'(e_data));
    check({tag, " carry"}, 32'(o_carry), 32'(e_c));
    check({tag, " zero"}, 32'(o_zero), 32'(e_z));
    check({tag, " ovf"}, 32'(o_overflow), 32'(e_v));
    check({tag, " neg"}, 32'(o_negative), 32'(e_n));
    check({tag, " err"}, 32'(o_error), 32'(e_err));
  endtask

  task automatic model_reset();
    ma = 0; mb = 0;
    e_data = 0; e_c = 0; e_z = 0;
    e_v = 0; e_n = 0; e_err = 0;
  endtask

  // Updates expected outputs for op on (ma, mb); lat is
  // the edge count from the first enable sample to valid.
  task automatic model(input logic [5:0] op,
                       output int lat);
    int r, sa, sb, sh;
    bit c, v, legal;
    sa = (ma > 127) ? ma - 256 : ma;
    sb = (mb > 127) ? mb - 256 : mb;
    sh = mb % N;
    r = 0; c = 0; v = 0; legal = 1; lat = 4;
    case (op)
      T_ADD: begin
        r = ma + mb; c = (r > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
      end
      T_SUB: begin
        r = ma + (255 - mb) + 1; c = (r > 255);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      T_AND: r = ma & mb;
      T_OR:  r = ma | mb;
      T_XOR: r = ma ^ mb;
      T_NOR: r = ~(ma | mb);
      T_SRL: r = ma >> sh;
      T_SRA: r = sa >>> sh;
      T_MUL: begin
        r = ma * mb; c = (r > 255); v = c;
        lat = 4 + N;
      end
      default: legal = 0;
    endcase
    if (legal) begin
      e_data = r & 255;
      e_c = c; e_v = v;
      e_z = (e_data == 0);
      e_n = (e_data >= 128);
      e_err = 0;
    end else begin
      e_err = 1;
    end
  endtask

  task automatic press(input int which,
                       input logic [7:0] val);
    @(negedge clk);
    i_data = val;
    if (which == 1) en1 = 1'b1; else en2 = 1'b1;
    repeat (3) @(negedge clk);
    en1 = 1'b0; en2 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_ab(input logic [7:0] a,
                         input logic [7:0] b);
    press(1, a); ma = a;
    press(2, b); mb = b;
  endtask

  task automatic run_op(input logic [5:0] op,
                        input string tag,
                        input bit poke);
    int lat, n;
    bit seen;
    model(op, lat);
    @(negedge clk);
    i_data = {2'b00, op};
    en3 = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (o_valid) seen = 1;
      else check({tag, " busy"}, 32'(o_busy),
                 32'(n >= 3));
      if (poke && n == 5) begin
        i_data = 8'hA5;
        en1 = 1'b1; en2 = 1'b1;
      end
    end
    check({tag, " latency"}, n, lat);
    if (seen) begin
      check_outs(tag);
      check({tag, " busy@valid"}, 32'(o_busy), 0);
    end
    @(posedge clk); #1;
    check({tag, " valid width"}, 32'(o_valid), 0);
    @(negedge clk);
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int vcount, idx;
    logic [5:0] op;
    rst_n = 1'b0;
    i_data = '0;
    en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    model_reset();
    #1;
    check_outs("reset");
    check("reset valid", 32'(o_valid), 0);
    check("reset busy", 32'(o_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    load_ab(8'h7F, 8'h01);
    run_op(T_ADD, "add_ovf", 0);
    load_ab(8'h05, 8'h05);
    run_op(T_SUB, "sub_zero", 0);
    load_ab(8'h00, 8'h01);
    run_op(T_SUB, "sub_borrow", 0);
    load_ab(8'h80, 8'h03);
    run_op(T_SRA, "sra", 0);
    run_op(T_SRL, "srl", 0);
    load_ab(8'h10, 8'h10);
    run_op(T_MUL, "mul_hi", 1);
    run_op(T_ADD, "add_after_busy", 0);
    run_op(6'b111111, "illegal", 0);
    run_op(T_ADD, "err_clear", 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        press(1, 8'($urandom)); ma = int'(dut.i_data);
      end
      if ($urandom_range(0, 3) != 0) begin
        press(2, 8'($urandom)); mb = int'(i_data);
      end
      idx = $urandom_range(0, 9);
      if (idx == 9) op = 6'($urandom);
      else op = ops[idx];
      run_op(op, "rand", 0);
    end

    // Abort a multiply with reset while enable_3 is held.
    @(negedge clk);
    i_data = {2'b00, T_MUL};
    en3 = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    i_data = {2'b00, T_ADD};
    #1;
    model_reset();
    check_outs("mid_mul_reset");
    check("mid_mul_reset valid", 32'(o_valid), 0);
    check("mid_mul_reset busy", 32'(o_busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (o_valid) vcount++;
    end
    begin
      int lat;
      model(T_ADD, lat);
    end
    check("held en3 loads once", vcount, 1);
    check_outs("held en3 add");
    en3 = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
